// File: rtl/dout_fifo_pkg.sv
// Shared constants for the output-side FIFO of the AM mod/demod datapath.
// Holds the default word lengths, the Q-format saturation limits and the
// width of the saturation debug counter.
package dout_fifo_pkg;

    // Default word lengths: Q17.0 filter results in, Q15.0 samples out.
    localparam int unsigned DIN_WORDLENGTH_DEF  = 18;
    localparam int unsigned DOUT_WORDLENGTH_DEF = 16;
    localparam int unsigned DROP_LSBS_DEF       = 2;

    // Saturation limits of the default Q15.0 output word.
    localparam int DOUT_MAX_DEF = 32767;
    localparam int DOUT_MIN_DEF = -32768;

    // Width of the saturating saturation-event counter.
    localparam int unsigned SAT_CNT_WIDTH = 16;

    // Largest positive value of a signed word of the given width.
    function automatic int q_max(input int unsigned wl);
        return (1 << (wl - 1)) - 1;
    endfunction

    // Most negative value of a signed word of the given width.
    function automatic int q_min(input int unsigned wl);
        return -(1 << (wl - 1));
    endfunction

endpackage

// File: rtl/dout_ram_model_1w1r.sv
// Storage array for dout_fifo: one synchronous write port, one asynchronous
// read port. A depth of one (LOG2_DEPTH = 0) collapses to a single register
// so that no zero-width address is ever needed.
module dout_ram_model_1w1r #(
    parameter int unsigned LOG2_DEPTH = 2,
    parameter int unsigned WIDTH      = 16,
    // Address width, kept at least one bit for the single-entry build.
    parameter int unsigned ADR_W      = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1
) (
    input  logic             CLK,
    input  logic [ADR_W-1:0] WADR,
    input  logic             WEN,
    input  logic [WIDTH-1:0] WDAT,
    input  logic [ADR_W-1:0] RADR,
    output logic [WIDTH-1:0] RDAT
);

    localparam int unsigned DEPTH = 2 ** LOG2_DEPTH;

    if (LOG2_DEPTH == 0) begin : g_single
        logic [WIDTH-1:0] mem_q;
        // The only entry lives at address 0, so the addresses carry no information.
        logic             unused_adr;

        // Single-entry store.
        always_ff @(posedge CLK) begin
            if (WEN) begin
                mem_q <= WDAT;
            end
        end

        assign RDAT       = mem_q;
        assign unused_adr = ^{WADR, RADR};
    end else begin : g_array
        logic [WIDTH-1:0] mem_q [DEPTH];

        // Write port; contents are intentionally not reset.
        always_ff @(posedge CLK) begin
            if (WEN) begin
                mem_q[WADR] <= WDAT;
            end
        end

        assign RDAT = mem_q[RADR];
    end

endmodule

// File: rtl/dout_fifo.sv
// Output-side buffer of the AM mod/demod datapath. Accepts wide Q17.0
// results over an RTS/RTR handshake, requantizes them to Q15.0 with
// round-half-up and saturation, buffers them in a small circular FIFO and
// presents them downstream over a second RTS/RTR handshake. A sticky flag
// and a saturating counter record saturation events on accepted samples.
module dout_fifo
    import dout_fifo_pkg::*;
#(
    parameter int unsigned LOG2_DEPTH      = 2,
    parameter int unsigned DIN_WORDLENGTH  = DIN_WORDLENGTH_DEF,
    parameter int unsigned DOUT_WORDLENGTH = DOUT_WORDLENGTH_DEF,
    parameter int unsigned DROP_LSBS       = DROP_LSBS_DEF
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       DOUT_IN_RTS,
    output logic                       DOUT_IN_RTR,
    input  logic [DIN_WORDLENGTH-1:0]  DOUT_DIN_DAT,
    output logic                       DOUT_OUT_RTS,
    input  logic                       DOUT_OUT_RTR,
    output logic [DOUT_WORDLENGTH-1:0] DOUT_DAT,
    output logic                       DOUT_SAT_FLAG,
    output logic [SAT_CNT_WIDTH-1:0]   DOUT_SAT_CNT
);

    // Pointers keep one bit even for the single-entry build; they stay at 0 there.
    localparam int unsigned PTR_W = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;
    localparam int unsigned CNT_W = LOG2_DEPTH + 1;
    // One guard bit so the rounding constant can never overflow the input range.
    localparam int unsigned R_W   = DIN_WORDLENGTH + 1;

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(2 ** LOG2_DEPTH);

    // Half an output LSB expressed in input LSBs; zero when nothing is dropped.
    localparam logic [R_W-1:0] RND = R_W'(2 ** DROP_LSBS) >> 1;

    // Output range limits, widened to the intermediate width for comparison.
    localparam logic signed [R_W-1:0] S_MAX = R_W'(q_max(DOUT_WORDLENGTH));
    localparam logic signed [R_W-1:0] S_MIN = R_W'(q_min(DOUT_WORDLENGTH));

    localparam logic [DOUT_WORDLENGTH-1:0] DOUT_MAX = {1'b0, {(DOUT_WORDLENGTH - 1){1'b1}}};
    localparam logic [DOUT_WORDLENGTH-1:0] DOUT_MIN = {1'b1, {(DOUT_WORDLENGTH - 1){1'b0}}};

    // Round-half-up and saturate one input word. Returns {sat, word}.
    function automatic logic [DOUT_WORDLENGTH:0] requant(
        input logic [DIN_WORDLENGTH-1:0] din
    );
        logic signed [R_W-1:0] r;
        logic signed [R_W-1:0] s;
        r = $signed({din[DIN_WORDLENGTH-1], din}) + $signed(RND);
        s = r >>> DROP_LSBS;
        if (s > S_MAX) begin
            return {1'b1, DOUT_MAX};
        end else if (s < S_MIN) begin
            return {1'b1, DOUT_MIN};
        end else begin
            return {1'b0, s[DOUT_WORDLENGTH-1:0]};
        end
    endfunction

    logic [PTR_W-1:0]           wptr_q, wptr_d;
    logic [PTR_W-1:0]           rptr_q, rptr_d;
    logic [CNT_W-1:0]           num_q, num_d;
    logic                       sat_flag_q, sat_flag_d;
    logic [SAT_CNT_WIDTH-1:0]   sat_cnt_q, sat_cnt_d;

    logic                       in_xfc;
    logic                       out_xfc;
    logic                       req_sat;
    logic [DOUT_WORDLENGTH-1:0] req_dat;

    // Handshake outputs drop combinationally while RESET is high.
    assign DOUT_IN_RTR  = (num_q < DEPTH_CNT) & ~RESET;
    assign DOUT_OUT_RTS = (num_q != '0) & ~RESET;

    assign in_xfc  = DOUT_IN_RTS & DOUT_IN_RTR;
    assign out_xfc = DOUT_OUT_RTS & DOUT_OUT_RTR;

    // Requantize the incoming word on the write path.
    always_comb begin
        {req_sat, req_dat} = requant(DOUT_DIN_DAT);
    end

    // Next-state for pointers, occupancy and saturation bookkeeping.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        num_d      = num_q;
        sat_flag_d = sat_flag_q;
        sat_cnt_d  = sat_cnt_q;

        if (in_xfc) begin
            wptr_d = (LOG2_DEPTH == 0) ? '0 : wptr_q + PTR_ONE;
        end
        if (out_xfc) begin
            rptr_d = (LOG2_DEPTH == 0) ? '0 : rptr_q + PTR_ONE;
        end

        if (in_xfc && !out_xfc) begin
            num_d = num_q + CNT_ONE;
        end else if (out_xfc && !in_xfc) begin
            num_d = num_q - CNT_ONE;
        end

        // Only accepted samples count; the counter sticks at all-ones.
        if (in_xfc && req_sat) begin
            sat_flag_d = 1'b1;
            if (sat_cnt_q != '1) begin
                sat_cnt_d = sat_cnt_q + SAT_CNT_WIDTH'(1);
            end
        end
    end

    // State register with synchronous reset; buffered words are discarded.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            num_q      <= '0;
            sat_flag_q <= 1'b0;
            sat_cnt_q  <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            num_q      <= num_d;
            sat_flag_q <= sat_flag_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

    assign DOUT_SAT_FLAG = sat_flag_q;
    assign DOUT_SAT_CNT  = sat_cnt_q;

    dout_ram_model_1w1r #(
        .LOG2_DEPTH (LOG2_DEPTH),
        .WIDTH      (DOUT_WORDLENGTH),
        .ADR_W      (PTR_W)
    ) u_ram (
        .CLK  (CLK),
        .WADR (wptr_q),
        .WEN  (in_xfc),
        .WDAT (req_dat),
        .RADR (rptr_q),
        .RDAT (DOUT_DAT)
    );

endmodule

// File: tb/tb_dout_fifo.sv
// Self-checking bench for dout_fifo: directed sequences, a requantizer vector
// table, randomized traffic against a queue-based reference model, and a
// single-entry build.
module tb_dout_fifo;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        in_rts, in_rtr, out_rts, out_rtr, sat_flag;
    logic [17:0] din;
    logic [15:0] dat, sat_cnt;
    logic        in0_rts, in0_rtr, out0_rts, out0_rtr, sat0_flag;
    logic [17:0] din0;
    logic [15:0] dat0, sat0_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int mq[$];
    int m_cnt;
    bit m_flag;

    typedef struct {
        int din;
        int exp;
        bit sat;
    } vec_t;

    always #5 CLK = ~CLK;

    dout_fifo dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .DOUT_IN_RTS   (in_rts),
        .DOUT_IN_RTR   (in_rtr),
        .DOUT_DIN_DAT  (din),
        .DOUT_OUT_RTS  (out_rts),
        .DOUT_OUT_RTR  (out_rtr),
        .DOUT_DAT      (dat),
        .DOUT_SAT_FLAG (sat_flag),
        .DOUT_SAT_CNT  (sat_cnt)
    );

    dout_fifo #(.LOG2_DEPTH(0)) dut0 (
        .CLK           (CLK),
        .RESET         (RESET),
        .DOUT_IN_RTS   (in0_rts),
        .DOUT_IN_RTR   (in0_rtr),
        .DOUT_DIN_DAT  (din0),
        .DOUT_OUT_RTS  (out0_rts),
        .DOUT_OUT_RTR  (out0_rtr),
        .DOUT_DAT      (dat0),
        .DOUT_SAT_FLAG (sat0_flag),
        .DOUT_SAT_CNT  (sat0_cnt)
    );

    // Q17.0 -> Q15.0: divide by 4, round half up, clamp to the 16-bit range.
    function automatic int mdl_q(input int x, output bit sat);
        real y;
        int  v;
        y   = $floor(real'(x) / 4.0 + 0.5);
        v   = int'(y);
        sat = 1'b0;
        if (v > 32767) begin
            v   = 32767;
            sat = 1'b1;
        end else if (v < -32768) begin
            v   = -32768;
            sat = 1'b1;
        end
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_cnt  = 0;
        m_flag = 1'b0;
    endtask

    // One clock cycle on the main DUT, checked against the model.
    task automatic step(input bit rts, input int d, input bit rtr);
        bit exp_rtr, exp_rts, s;
        int q;
        in_rts  = rts;
        din     = 18'(d);
        out_rtr = rtr;
        #2;
        exp_rtr = (mq.size() < 4);
        exp_rts = (mq.size() > 0);
        chk("in_rtr", int'(in_rtr), int'(exp_rtr));
        chk("out_rts", int'(out_rts), int'(exp_rts));
        if (exp_rts) chk("dout_dat", int'($signed(dat)), mq[0]);
        chk("sat_flag", int'(sat_flag), int'(m_flag));
        chk("sat_cnt", int'(sat_cnt), m_cnt);
        @(posedge CLK);
        if (exp_rts && rtr) void'(mq.pop_front());
        if (exp_rtr && rts) begin
            q = mdl_q(d, s);
            mq.push_back(q);
            if (s) begin
                m_flag = 1'b1;
                if (m_cnt < 65535) m_cnt++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        RESET   = 1'b1;
        in_rts  = 1'b0;
        out_rtr = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_clear();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[16];
        int   seq_exp[4];
        int   exp_cnt;
        bit   cur_rts, cur_rtr, hold, full0, s0;
        int   cur_d, held0, d0;

        RESET    = 1'b1;
        in_rts   = 1'b0;
        out_rtr  = 1'b0;
        din      = '0;
        in0_rts  = 1'b0;
        out0_rtr = 1'b0;
        din0     = '0;
        model_clear();

        // Reset state: handshakes low while RESET is held.
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_in_rtr", int'(in_rtr), 0);
        chk("rst_out_rts", int'(out_rts), 0);
        chk("rst_sat_flag", int'(sat_flag), 0);
        chk("rst_sat_cnt", int'(sat_cnt), 0);
        RESET = 1'b0;

        // Fill with 4 words while downstream stalls, then drain.
        step(1, 4, 0);
        step(1, 8, 0);
        step(1, -4, 0);
        step(1, -9, 0);
        #1;
        chk("fill_in_rtr", int'(in_rtr), 0);
        chk("fill_out_rts", int'(out_rts), 1);
        seq_exp = '{1, 2, -1, -2};
        for (int i = 0; i < 4; i++) begin
            out_rtr = 1'b1;
            #1;
            chk("drain_dat", int'($signed(dat)), seq_exp[i]);
            step(0, 0, 1);
        end
        #1;
        chk("drain_out_rts", int'(out_rts), 0);

        // Requantizer vectors, one word through the empty FIFO at a time.
        do_reset();
        tbl = '{
            '{4, 1, 0},       '{8, 2, 0},       '{-4, -1, 0},      '{-9, -2, 0},
            '{131071, 32767, 1}, '{-131072, -32768, 0}, '{6, 2, 0}, '{5, 1, 0},
            '{-6, -1, 0},     '{7, 2, 0},       '{131070, 32767, 1}, '{131069, 32767, 0},
            '{-131071, -32768, 0}, '{-2, 0, 0}, '{-3, -1, 0},      '{2, 1, 0}
        };
        exp_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1, tbl[i].din, 0);
            if (tbl[i].sat) exp_cnt++;
            chk("tbl_dat", int'($signed(dat)), tbl[i].exp);
            chk("tbl_sat_cnt", int'(sat_cnt), exp_cnt);
            chk("tbl_sat_flag", int'(sat_flag), int'(exp_cnt > 0));
            step(0, 0, 1);
        end

        // Full buffer with both sides requesting: only the read happens.
        do_reset();
        for (int i = 1; i <= 4; i++) step(1, 100 * i, 0);
        step(1, 500, 1);
        chk("full_rd_rts", int'(out_rts), 1);
        chk("full_rd_rtr", int'(in_rtr), 1);
        step(1, 500, 0);
        chk("full_refill_rtr", int'(in_rtr), 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1);
        chk("full_empty_rts", int'(out_rts), 0);

        // Continuous streaming across several pointer wraps.
        for (int i = 0; i < 21; i++) begin
            step(1, 4 * i + 1, 1);
            chk("stream_rts", int'(out_rts), 1);
            chk("stream_rtr", int'(in_rtr), 1);
        end
        step(0, 0, 1);

        // Reset mid-operation with 3 words and 2 saturations.
        do_reset();
        step(1, 131071, 0);
        step(1, 131071, 0);
        step(1, 12, 0);
        chk("mid_sat_cnt", int'(sat_cnt), 2);
        RESET   = 1'b1;
        in_rts  = 1'b1;
        out_rtr = 1'b1;
        #1;
        chk("mid_rst_in_rtr", int'(in_rtr), 0);
        chk("mid_rst_out_rts", int'(out_rts), 0);
        @(posedge CLK);
        #1;
        RESET  = 1'b0;
        in_rts = 1'b0;
        model_clear();
        #1;
        chk("post_rst_rts", int'(out_rts), 0);
        chk("post_rst_rtr", int'(in_rtr), 1);
        chk("post_rst_flag", int'(sat_flag), 0);
        chk("post_rst_cnt", int'(sat_cnt), 0);
        step(1, 40, 0);
        chk("post_rst_dat", int'($signed(dat)), 10);
        step(0, 0, 1);

        // Randomized traffic; upstream holds its word while stalled.
        do_reset();
        cur_rts = 1'b0;
        cur_d   = 0;
        for (int i = 0; i < 400; i++) begin
            hold = cur_rts && (mq.size() >= 4);
            if (!hold) begin
                cur_rts = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 3) == 0)
                    cur_d = ($urandom_range(0, 1) != 0) ? 131072 - int'($urandom_range(1, 8))
                                                        : -131072 + int'($urandom_range(0, 7));
                else
                    cur_d = int'($urandom_range(0, 262143)) - 131072;
            end
            cur_rtr = ($urandom_range(0, 2) != 0);
            step(cur_rts, cur_d, cur_rtr);
        end
        while (mq.size() > 0) step(0, 0, 1);

        // Single-entry build: accept and release alternate, words pass intact.
        full0    = 1'b0;
        held0    = 0;
        d0       = 0;
        in0_rts  = 1'b1;
        out0_rtr = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (!full0) d0 = 8 * (k + 1) + 4;
            din0 = 18'(d0);
            #2;
            chk("d0_in_rtr", int'(in0_rtr), int'(!full0));
            chk("d0_out_rts", int'(out0_rts), int'(full0));
            if (full0) chk("d0_dat", int'($signed(dat0)), mdl_q(held0, s0));
            @(posedge CLK);
            if (full0) full0 = 1'b0;
            else begin
                held0 = d0;
                full0 = 1'b1;
            end
            #1;
        end
        in0_rts  = 1'b0;
        out0_rtr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dout_fifo.md
# dout_fifo

Output-side buffer of the AM mod/demod datapath, the mirror of the input FIFO. It accepts wide filter/demodulator results (Q17.0) over an RTS/RTR handshake and requantizes each to the 16-bit output word (Q15.0) by round-half-up and saturation. It stores the words in a small circular buffer and presents them downstream over a second RTS/RTR handshake. It also keeps a sticky saturation flag and a saturating saturation-event counter for debug and verification.

## Interface
Parameters:
- LOG2_DEPTH, 2, log2 of buffer depth (depth = 4 words); 0 is legal and gives a 1-entry buffer
- DIN_WORDLENGTH, 18, input word width, signed Q17.0
- DOUT_WORDLENGTH, 16, output word width, signed Q15.0
- DROP_LSBS, 2, LSBs removed by rounding; DIN_WORDLENGTH - DROP_LSBS must be >= DOUT_WORDLENGTH

Ports:
- CLK  in  1  single clock, all state on rising edge
- RESET  in  1  synchronous, active-high reset
- DOUT_IN_RTS  in  1  upstream ready-to-send
- DOUT_IN_RTR  out  1  block ready-to-receive
- DOUT_DIN_DAT  in  DIN_WORDLENGTH  signed input sample
- DOUT_OUT_RTS  out  1  block ready-to-send
- DOUT_OUT_RTR  in  1  downstream ready-to-receive
- DOUT_DAT  out  DOUT_WORDLENGTH  signed output sample, valid only while DOUT_OUT_RTS=1
- DOUT_SAT_FLAG  out  1  sticky: at least one accepted sample saturated since reset
- DOUT_SAT_CNT  out  16  number of saturated accepted samples, stops at 16'hFFFF

## Operation
- in_xfc = DOUT_IN_RTS & DOUT_IN_RTR; out_xfc = DOUT_OUT_RTS & DOUT_OUT_RTR.
- DOUT_IN_RTR = (num_in_buf < 2^LOG2_DEPTH) & ~RESET; DOUT_OUT_RTS = (num_in_buf > 0) & ~RESET. Both are combinational from registered state plus RESET.
- State: wptr, rptr (LOG2_DEPTH bits, wrap naturally; forced to 0 when LOG2_DEPTH=0), num_in_buf (LOG2_DEPTH+1 bits).
- num_in_buf: +1 on in_xfc only, −1 on out_xfc only, unchanged on both or neither. wptr += 1 on in_xfc. rptr += 1 on out_xfc.
- Requantize on the write path, combinationally:
  - r = sext(DOUT_DIN_DAT, DIN_WORDLENGTH+1) + 2^(DROP_LSBS−1), or r = input if DROP_LSBS = 0.
  - s = r >>> DROP_LSBS (arithmetic shift).
  - If s > 2^(DOUT_WORDLENGTH−1)−1, store the max positive value and set sat. If s < −2^(DOUT_WORDLENGTH−1), store the min negative value and set sat. Otherwise store s truncated to DOUT_WORDLENGTH.
- Stored word written to RAM[wptr] on in_xfc. DOUT_DAT = RAM[rptr], read asynchronously.
- On in_xfc with sat=1: DOUT_SAT_FLAG <= 1, and DOUT_SAT_CNT increments unless already 16'hFFFF. Saturation on non-accepted cycles is ignored.
- Reset values: wptr=rptr=num_in_buf=0, DOUT_IN_RTR=0, DOUT_OUT_RTS=0, DOUT_SAT_FLAG=0, DOUT_SAT_CNT=0. RAM contents are not cleared. DOUT_DAT is don't-care while DOUT_OUT_RTS=0.

## Timing
- Latency: a word accepted at edge N is visible on DOUT_DAT with DOUT_OUT_RTS=1 after edge N when the buffer was empty. There is no same-cycle bypass.
- Throughput: one in and one out per cycle when 0 < num_in_buf < depth.
- Full: DOUT_IN_RTR=0 even if DOUT_OUT_RTR=1 in that cycle. Write is re-enabled the cycle after a read.
- Empty: DOUT_OUT_RTS=0, and a simultaneous input is only written.
- Pointer wrap: index 2^LOG2_DEPTH−1 → 0 with no data loss. Order is strictly FIFO.
- RESET asserted mid-operation: both RTR and RTS drop in the same cycle (combinational). All buffered words are discarded at the next edge. Counters clear. The first accept is possible in the cycle after RESET deasserts.
- Upstream and downstream must hold data stable while RTS=1 and RTR=0. The block holds DOUT_DAT stable until out_xfc.

## Structure
- Shared package holds the default word lengths (18, 16), DROP_LSBS default, the Q-format saturation limits, and the saturation counter width (16).
- One sub-module, dout_ram_model_1w1r: 1 write port (WADR, WEN, WDAT), 1 asynchronous read port (RADR, RDAT), DOUT_WORDLENGTH × 2^LOG2_DEPTH.
- Requantizer stays inline in dout_fifo as a combinational function.

## Test plan
- Reset then write 4 samples 4, 8, −4, −9 with DOUT_OUT_RTR=0 → DOUT_IN_RTR falls after the 4th. Then raise DOUT_OUT_RTR → DOUT_DAT sequence 1, 2, −1, −2 (−9 rounds to −2.25 → −2), and DOUT_OUT_RTS falls after the 4th.
- Input 131071 → output 32767, DOUT_SAT_FLAG=1, DOUT_SAT_CNT=1. Input −131072 → −32768 with no saturation, count stays 1. Input 6 → 2 (1.5 rounds up).
- Continuous streaming with both RTS and RTR held high for 20 samples → num_in_buf stays at 1, order preserved across 5 pointer wraps, zero lost or duplicated words.
- Full buffer with DOUT_IN_RTS=1 and DOUT_OUT_RTR=1 → only the read occurs. The next cycle accepts the write, and num_in_buf returns to 4.
- Assert RESET for 1 cycle with 3 words buffered and 2 saturations counted → RTS/RTR go low immediately. Next cycle num_in_buf=0, DOUT_SAT_FLAG=0, DOUT_SAT_CNT=0. A new word 40 then reads back as 10.
- LOG2_DEPTH=0 build → single-entry behaviour: alternating accept and release, pointers fixed at 0.
